mem_stage_unit: RTL and testbench

Parametrised memory-access stage for the pipelined MIPS core: successor to the fixed RAM/ROM read mux in the MEM stage. Decodes each request by address region into on-chip RAM, external sort-data ROM, or a small MMIO register file. Supports byte/half/word loads with sign/zero extension, byte-lane stores, multi-cycle ROM reads with a valid/ready stall, and fault reporting. Sits between the EX/MEM pipeline register and the MEM/WB register; `req_ready` drives the pipeline stall.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_unit_load_align.sv | 35 +++
 rtl/mem_stage_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage unit: access sizes, FSM states, default
// region codes and the byte-lane helpers used by stores.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [3:0] RAM_REGION_DEF  = 4'h1;
    localparam logic [3:0] ROM_REGION_DEF  = 4'h3;
    localparam logic [3:0] MMIO_REGION_DEF = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ROM_WAIT = 2'd1,
        S_RESP     = 2'd2
    } state_t;

    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_en = 4'b0001 << off;
            SZ_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    endfunction

    // Store data arrives right-aligned; copy it into every lane so the
    // enables alone pick the destination bytes.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: lane_data = {4{wdata[7:0]}};
            SZ_HALF: lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_unit_load_align.sv
// Load alignment: picks the byte/half lane addressed by off and sign- or
// zero-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        half_v = 16'h0000;
        data   = 32'h0;
        case (off)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: data = {{24{byte_v[7] & ~uns}}, byte_v};
            SZ_HALF: data = {{16{half_v[15] & ~uns}}, half_v};
            SZ_WORD: data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM-stage access unit: decodes RAM / external ROM / MMIO by addr[31:28],
// handles sized loads and stores, stalls on ROM reads and reports faults.
module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int         RAM_WORDS   = 256,
    parameter int         ROM_WORDS   = 256,
    parameter int         ROM_LAT     = 2,
    parameter int         N_MMIO      = 4,
    parameter logic [3:0] RAM_REGION  = RAM_REGION_DEF,
    parameter logic [3:0] ROM_REGION  = ROM_REGION_DEF,
    parameter logic [3:0] MMIO_REGION = MMIO_REGION_DEF,
    localparam int        RAM_AW      = $clog2(RAM_WORDS),
    localparam int        ROM_AW      = $clog2(ROM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [31:0]           rom_rdata,
    output logic [32*N_MMIO-1:0]  mmio_q
);

    localparam int MMIO_IW = (N_MMIO > 1) ? $clog2(N_MMIO) : 1;
    localparam int CNT_W   = $clog2(ROM_LAT) + 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [31:0]         word_q, word_d;
    logic [1:0]          off_q, off_d, size_q, size_d;
    logic                uns_q, uns_d, fault_q, fault_d, write_q, write_d;
    logic [31:0]         mmio_regs_q [N_MMIO];
    logic [31:0]         mmio_regs_d [N_MMIO];
    logic [31:0]         ram [RAM_WORDS];

    logic [3:0]          region, be;
    logic [31:0]         wd;
    logic                in_ram, in_rom, in_mmio, misaligned, req_fault, accept;
    logic [3:0]          ram_be;
    logic [RAM_AW-1:0]   ram_idx;
    logic [MMIO_IW-1:0]  mmio_idx;
    logic [3:0]          mmio_sel;
    logic [31:0]         aligned;
    logic                unused_addr;

    assign region   = req_addr[31:28];
    assign in_ram   = (region == RAM_REGION);
    assign in_rom   = (region == ROM_REGION);
    assign in_mmio  = (region == MMIO_REGION);
    assign ram_idx  = req_addr[RAM_AW+1:2];
    assign mmio_sel = req_addr[5:2];
    assign mmio_idx = req_addr[MMIO_IW+1:2];
    assign be       = lane_en(req_size, req_addr[1:0]);
    assign wd       = lane_data(req_size, req_wdata);
    assign unused_addr = ^req_addr;

    assign misaligned = (req_size == SZ_ILL)
                      | ((req_size == SZ_HALF) & req_addr[0])
                      | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
    assign req_fault  = (req_read == req_write) | misaligned
                      | ~(in_ram | in_rom | in_mmio)
                      | (in_rom & req_write)
                      | (in_mmio & ({1'b0, mmio_sel} >= 5'(N_MMIO)));

    // Every valid request offered in IDLE is taken; faulting ones just answer.
    assign req_ready = reset & (state_q == S_IDLE);
    assign accept    = req_ready & req_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        word_d     = word_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        fault_d    = fault_q;
        write_d    = write_q;
        mmio_regs_d = mmio_regs_q;
        ram_be     = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    write_d = req_write;
                    fault_d = req_fault;
                    word_d  = 32'h0;
                    if (req_fault) begin
                        state_d = S_RESP;
                    end else if (in_rom) begin
                        rom_addr_d = req_addr[ROM_AW+1:2];
                        cnt_d      = CNT_W'(ROM_LAT - 1);
                        state_d    = S_ROM_WAIT;
                    end else begin
                        state_d = S_RESP;
                        if (in_ram) begin
                            if (req_write) ram_be = be;
                            else           word_d = ram[ram_idx];
                        end else if (req_write) begin
                            for (int b = 0; b < 4; b++)
                                if (be[b]) mmio_regs_d[mmio_idx][8*b +: 8] = wd[8*b +: 8];
                        end else begin
                            word_d = mmio_regs_q[mmio_idx];
                        end
                    end
                end
            end
            S_ROM_WAIT: begin
                if (cnt_q == '0) begin
                    word_d  = rom_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            word_q     <= 32'h0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            fault_q    <= 1'b0;
            write_q    <= 1'b0;
            for (int i = 0; i < N_MMIO; i++) mmio_regs_q[i] <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            word_q     <= word_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            fault_q    <= fault_d;
            write_q    <= write_d;
            mmio_regs_q <= mmio_regs_d;
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram[ram_idx][8*b +: 8] <= wd[8*b +: 8];
    end

    load_align u_align (
        .word (word_q),
        .off  (off_q),
        .size (size_q),
        .uns  (uns_q),
        .data (aligned)
    );

    assign resp_valid = (state_q == S_RESP);
    assign resp_fault = resp_valid & fault_q;
    assign resp_rdata = (resp_valid & ~fault_q & ~write_q) ? aligned : 32'h0;
    assign rom_addr   = rom_addr_q;

    for (genvar i = 0; i < N_MMIO; i++) begin : g_mmio_out
        assign mmio_q[32*i +: 32] = mmio_regs_q[i];
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed cases with literal expectations, then
// random traffic checked every cycle against a byte-level model.
module tb_mem_stage_unit;

    localparam int ROM_LAT = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]   req_size = 2'd0;
    logic [31:0]  req_addr = 32'h0, req_wdata = 32'h0;
    logic         req_ready, resp_valid, resp_fault;
    logic [31:0]  resp_rdata, rom_rdata;
    logic [7:0]   rom_addr;
    logic [127:0] mmio_q;

    always #5 clk = ~clk;

    mem_stage_unit #(.ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata), .mmio_q(mmio_q)
    );

    // External ROM: one register of delay, so data for an address presented
    // after the accept edge is usable on the last wait cycle and not earlier.
    logic [31:0] rom_m [256];
    logic [7:0]  rom_d1;
    always @(posedge clk) rom_d1 <= rom_addr;
    assign rom_rdata = rom_m[rom_d1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
        logic        is_rom;
        logic [7:0]  rom_idx;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ram_m  [256];
    logic [31:0] mmio_m [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour of one request, applied at its accept edge.
    function automatic void model_req(input bit rd, input bit wr, input logic [1:0] sz,
                                      input bit uns, input logic [31:0] a, input logic [31:0] wdat,
                                      output logic [31:0] rdata, output bit fault, output bit is_rom);
        int nb, off;
        logic [3:0] r;
        logic [31:0] w, v, mask;
        r = a[31:28];
        off = int'(a[1:0]);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        fault = (rd == wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
             || !(r == 4'h1 || r == 4'h3 || r == 4'h4) || (r == 4'h3 && wr)
             || (r == 4'h4 && a[5:2] >= 4'd4);
        is_rom = !fault && (r == 4'h3);
        rdata = 32'h0;
        if (fault) return;
        if (wr) begin
            w = (r == 4'h1) ? ram_m[a[9:2]] : mmio_m[a[3:2]];
            for (int k = 0; k < nb; k++) w[(off + k)*8 +: 8] = wdat[k*8 +: 8];
            if (r == 4'h1) ram_m[a[9:2]] = w;
            else           mmio_m[a[3:2]] = w;
        end else begin
            w = (r == 4'h1) ? ram_m[a[9:2]] : (r == 4'h3) ? rom_m[a[9:2]] : mmio_m[a[3:2]];
            v = w >> (8*off);
            if (nb < 4) begin
                mask = (32'h1 << (8*nb)) - 32'h1;
                v = v & mask;
                if (!uns && v[8*nb-1]) v = v | ~mask;
            end
            rdata = v;
        end
    endfunction

    task automatic do_req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wdat);
        int waited;
        logic [31:0] rdata;
        bit fault, is_rom;
        exp_t e;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wdat;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, need 1", waited);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_req(rd, wr, sz, uns, a, wdat, rdata, fault, is_rom);
        e.rdata = rdata; e.fault = fault; e.is_rom = is_rom; e.rom_idx = a[9:2];
        e.cyc = cyc + (is_rom ? ROM_LAT + 1 : 1);
        exp_q.push_back(e);
        #1;
        req_valid = 1'b0;
        req_read = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_resp(input string name, input logic [31:0] exp_d, input logic exp_f);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({name, "_rdata"}, resp_rdata, exp_d);
        chk({name, "_fault"}, {31'h0, resp_fault}, {31'h0, exp_f});
    endtask

    // Per-cycle compare: ready only with nothing outstanding, response exactly
    // on its due cycle, ROM address held while waiting, MMIO mirrors the model.
    always @(negedge clk) begin
        bit busy, due;
        if (reset) begin
            busy = exp_q.size() > 0;
            due  = busy && (exp_q[0].cyc == cyc);
            chk("req_ready", {31'h0, req_ready}, {31'h0, !busy});
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, due});
            if (busy && exp_q[0].is_rom && !due)
                chk("rom_addr", {24'h0, rom_addr}, {24'h0, exp_q[0].rom_idx});
            if (due) begin
                chk("resp_rdata", resp_rdata, exp_q[0].rdata);
                chk("resp_fault", {31'h0, resp_fault}, {31'h0, exp_q[0].fault});
                void'(exp_q.pop_front());
            end else if (busy && exp_q[0].cyc < cyc) begin
                void'(exp_q.pop_front());
            end
            for (int i = 0; i < 4; i++) chk("mmio_q", mmio_q[32*i +: 32], mmio_m[i]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        bit          rd, wr;
        int          pick;
        for (int i = 0; i < 256; i++) rom_m[i] = $urandom;
        rom_m[2] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) mmio_m[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset_rdata", resp_rdata, 32'h0);
        chk("reset_mmio", mmio_q[31:0], 32'h0);
        reset = 1'b1;
        #1 chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10000000 + 32'(4*i), $urandom);

        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10000010, 32'h8899AABB);
        do_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h10000011, 32'h0);
        wait_resp("lbu", 32'h000000AA, 1'b0);
        do_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h10000013, 32'h0);
        wait_resp("lb", 32'hFFFFFF88, 1'b0);
        do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h10000012, 32'h00001234);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10000010, 32'h0);
        wait_resp("lw_after_sh", 32'h1234AABB, 1'b0);

        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h30000008, 32'h0);
        @(negedge clk);
        chk("rom_wait1_ready", {31'h0, req_ready}, 32'h0);
        chk("rom_wait1_addr", {24'h0, rom_addr}, 32'h2);
        @(negedge clk);
        chk("rom_wait2_ready", {31'h0, req_ready}, 32'h0);
        chk("rom_wait2_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("rom_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("rom_resp_rdata", resp_rdata, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10000002, 32'h0);
        wait_resp("misaligned_lw", 32'h0, 1'b1);
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h30000000, 32'hFFFFFFFF);
        wait_resp("rom_store", 32'h0, 1'b1);
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h70000010, 32'hFFFFFFFF);
        wait_resp("bad_region", 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10000010, 32'h0);
        wait_resp("ram_unchanged", 32'h1234AABB, 1'b0);

        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h40000004, 32'h5);
        @(negedge clk);
        chk("mmio1_store", mmio_q[63:32], 32'h5);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40000010, 32'h0);
        wait_resp("mmio_oob", 32'h0, 1'b1);
        do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h10000000, 32'h0);
        wait_resp("rd_and_wr", 32'h0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 9);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {a[1], 1'b0} : a[1:0];
            if (pick <= 4)      begin a[31:28] = 4'h1; a[9:2] = 8'($urandom_range(0, 15)); end
            else if (pick <= 6) a[31:28] = 4'h3;
            else if (pick <= 8) begin a[31:28] = 4'h4; a[5:2] = 4'($urandom_range(0, 5)); end
            else                a[31:28] = ($urandom_range(0, 1) == 1) ? 4'h7 : 4'h0;
            case ($urandom_range(0, 15))
                0:       begin rd = 1'b0; wr = 1'b0; end
                1:       begin rd = 1'b1; wr = 1'b1; end
                default: begin rd = 1'($urandom); wr = !rd; end
            endcase
            do_req(rd, wr, sz, 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h30000008, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) mmio_m[i] = 32'h0;
        #1 chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_mmio1", mmio_q[63:32], 32'h0);
        idle(5);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40000004, 32'h0);
        wait_resp("mmio_after_reset", 32'h0, 1'b0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
